// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative unsigned multiply/divide execute unit. It retires one bit per
//   cycle and produces a write-back triple for the register file.
//
//   Ports
//     clk               rising-edge clock
//     reset             asynchronous, active-high reset
//     start             request, sampled only while busy=0 (IDLE or DONE)
//     op                00 MUL lo, 01 MULHU hi, 10 UDIV quotient, 11 UREM remainder
//     destReg           destination register index
//     operandA          multiplicand / dividend
//     operandB          multiplier / divisor
//     busy              operation in flight; start is ignored
//     done              one-cycle completion pulse
//     writeReg          captured destReg, valid while done=1
//     writeData         result, held until the next completion
//     CONTROL_REGWRITE  regfile write strobe: done && writeReg != 31
//
//   Optional feature macro: MULDIV_EARLY_OUT_EN
//     When defined, a multiply with a zero operand or a divide by zero
//     completes after a single RUN cycle. Results are the same either way.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [REG_ADDR_W-1:0] destReg,
  input  logic [WIDTH-1:0]      operandA,
  input  logic [WIDTH-1:0]      operandB,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [WIDTH-1:0]      writeData,
  output logic                  CONTROL_REGWRITE
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_op;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [WIDTH-1:0]      r_a, r_b;
  // Shared accumulator pair:
  //   multiply: r_hi = partial product high half, r_lo = multiplier / product low half
  //   divide:   r_hi = partial remainder,          r_lo = dividend / quotient
  logic [WIDTH-1:0]      r_hi, r_lo;
  logic [WIDTH-1:0]      r_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_early;

  logic                  w_accept, w_last, w_early;
  logic [WIDTH:0]        w_mul_sum;
  logic [WIDTH-1:0]      w_mul_hi, w_mul_lo;
  logic [WIDTH:0]        w_div_sh;
  logic                  w_div_ge;
  logic [WIDTH-1:0]      w_div_diff, w_div_hi, w_div_lo;
  logic [WIDTH-1:0]      w_hi_nxt, w_lo_nxt, w_res_iter, w_res_early, w_res;

  // busy is low in DONE, so a start in the DONE cycle is accepted.
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_early || (r_cnt == LAST));

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = op[1] ? (operandB == '0) : ((operandA == '0) || (operandB == '0));
`else
  assign w_early = 1'b0;
`endif

  // Shift-add multiply step: add multiplicand on lsb of multiplier, shift right.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  // Restoring divide step, MSB first. The remainder stays below the divisor,
  // so the low WIDTH bits of the difference are exact when it is taken.
  // A zero divisor naturally yields all-ones quotient and remainder = dividend.
  assign w_div_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge   = w_div_sh >= {1'b0, r_b};
  assign w_div_diff = w_div_sh[WIDTH-1:0] - r_b;
  assign w_div_hi   = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
  assign w_div_lo   = {r_lo[WIDTH-2:0], w_div_ge};

  assign w_hi_nxt = r_op[1] ? w_div_hi : w_mul_hi;
  assign w_lo_nxt = r_op[1] ? w_div_lo : w_mul_lo;

  // op[0] selects the high register for both MULHU and UREM.
  assign w_res_iter  = r_op[0] ? w_hi_nxt : w_lo_nxt;
  assign w_res_early = r_op[1] ? (r_op[0] ? r_a : '1) : '0;
  assign w_res       = r_early ? w_res_early : w_res_iter;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= '0;
      r_dest  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_early <= 1'b0;
    end else if (w_accept) begin
      r_op    <= op;
      r_dest  <= destReg;
      r_a     <= operandA;
      r_b     <= operandB;
      r_hi    <= '0;
      r_lo    <= op[1] ? operandA : operandB;
      r_cnt   <= '0;
      r_early <= w_early;
    end else if (r_state == S_RUN) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_wdata <= w_res;
    end
  end

  assign busy             = (r_state == S_RUN);
  assign done             = (r_state == S_DONE);
  assign writeReg         = r_dest;
  assign writeData        = r_wdata;
  assign CONTROL_REGWRITE = done && (r_dest != REG_ADDR_W'(31));

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed, table-driven bench for muldiv_unit plus hand-written sequences
//   for busy-start, back-to-back start and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  destReg;
  logic [31:0] operandA, operandB;
  logic        busy, done, CONTROL_REGWRITE;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .destReg(destReg),
    .operandA(operandA), .operandB(operandB), .busy(busy), .done(done),
    .writeReg(writeReg), .writeData(writeData), .CONTROL_REGWRITE(CONTROL_REGWRITE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  dest;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (o[1] && b == 0) return 1;
    if (!o[1] && (a == 0 || b == 0)) return 1;
`endif
    return 32;
  endfunction

  // Call just before a rising edge; that edge is the accept edge.
  // Inputs are scrambled afterwards to show they have no effect.
  task automatic accept(input logic [1:0] o, input logic [4:0] d,
                        input logic [31:0] a, input logic [31:0] b);
    op = o; destReg = d; operandA = a; operandB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); destReg = 5'($urandom);
    operandA = $urandom; operandB = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: no done within %0d cycles", cyc);
    end
  endtask

  task automatic check_done(input string tag, input int cyc, input int lat,
                            input logic [4:0] d, input logic [31:0] exp);
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " data"},    writeData, exp);
    chk({tag, " reg"},     {27'b0, writeReg}, {27'b0, d});
    chk({tag, " regwr"},   {31'b0, CONTROL_REGWRITE}, {31'b0, (d != 5'd31)});
    chk({tag, " busy"},    {31'b0, busy}, 32'd0);
  endtask

  int cyc;
  bit saw_done;

  initial begin
    vecs[0]  = '{2'b00, 5'd3,  32'd7,        32'd6,        32'd42};
    vecs[1]  = '{2'b01, 5'd4,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{2'b00, 5'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[3]  = '{2'b10, 5'd6,  32'd100,      32'd7,        32'd14};
    vecs[4]  = '{2'b11, 5'd7,  32'd100,      32'd7,        32'd2};
    vecs[5]  = '{2'b10, 5'd8,  32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[6]  = '{2'b11, 5'd9,  32'd5,        32'd0,        32'd5};
    vecs[7]  = '{2'b00, 5'd31, 32'd3,        32'd3,        32'd9};
    vecs[8]  = '{2'b01, 5'd10, 32'h00010000, 32'h00030000, 32'h00000003};
    vecs[9]  = '{2'b10, 5'd11, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};
    vecs[10] = '{2'b00, 5'd12, 32'd0,        32'd1234,     32'd0};
    vecs[11] = '{2'b11, 5'd13, 32'd12345678, 32'd1000,     32'd678};

    reset = 1'b1; start = 1'b0; op = '0; destReg = '0; operandA = '0; operandB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy",  {31'b0, busy}, 32'd0);
    chk("rst done",  {31'b0, done}, 32'd0);
    chk("rst reg",   {27'b0, writeReg}, 32'd0);
    chk("rst data",  writeData, 32'd0);
    chk("rst regwr", {31'b0, CONTROL_REGWRITE}, 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      accept(vecs[i].op, vecs[i].dest, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, exp_lat(vecs[i].op, vecs[i].a, vecs[i].b) > 1});
      wait_done(cyc);
      check_done($sformatf("v%0d", i), cyc, exp_lat(vecs[i].op, vecs[i].a, vecs[i].b),
                 vecs[i].dest, vecs[i].exp);
      @(posedge clk); #1;
      chk($sformatf("v%0d pulse", i), {30'b0, done, CONTROL_REGWRITE}, 32'd0);
      chk($sformatf("v%0d hold", i), writeData, vecs[i].exp);
    end

    // start while busy is ignored; start in the DONE cycle is accepted
    @(negedge clk);
    accept(2'b10, 5'd14, 32'd9, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    accept(2'b00, 5'd15, 32'd2, 32'd2);
    chk("busy start ignored", {31'b0, busy}, 32'd1);
    wait_done(cyc);
    check_done("div under busy", cyc + 10, 32, 5'd14, 32'd3);
    accept(2'b00, 5'd15, 32'd2, 32'd2);
    chk("b2b busy", {31'b0, busy}, 32'd1);
    wait_done(cyc);
    check_done("b2b mul", cyc, 32, 5'd15, 32'd4);

    // reset at cycle 16 of a running divide
    @(negedge clk);
    accept(2'b10, 5'd16, 32'd1000, 32'd10);
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid rst busy",  {31'b0, busy}, 32'd0);
    chk("mid rst done",  {31'b0, done}, 32'd0);
    chk("mid rst data",  writeData, 32'd0);
    chk("mid rst regwr", {31'b0, CONTROL_REGWRITE}, 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("no done after rst", {31'b0, saw_done}, 32'd0);
    @(negedge clk);
    accept(2'b10, 5'd16, 32'd1000, 32'd10);
    wait_done(cyc);
    check_done("post rst div", cyc, 32, 5'd16, 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
